// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multi-cycle control sequencer.
// Opcodes, ALU ops, FSM states, pc_sel and halt codes.
package ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_ADDI = 7'h13;
  localparam logic [6:0] OP_LW   = 7'h03;
  localparam logic [6:0] OP_SW   = 7'h23;
  localparam logic [6:0] OP_BEQ  = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6f;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic [1:0] PC_P4    = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JAL   = 2'b10;
  localparam logic [1:0] PC_ENTRY = 2'b11;

  localparam logic [1:0] HC_NONE = 2'b00;
  localparam logic [1:0] HC_ILL  = 2'b01;
  localparam logic [1:0] HC_TO   = 2'b10;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_ENTRY  = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       alu_src;
    logic [2:0] op;
    logic       is_lw;
    logic       is_sw;
    logic       is_br;
    logic       is_jal;
    logic       wb_en;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational decode of the latched opcode/funct3/i30.
// Illegal encodings yield an all-zero bundle.
module mc_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       i30,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (opcode == OP_R): begin
        unique case (f3)
          3'b000: begin
            dec.legal = 1'b1;
            dec.wb_en = 1'b1;
            dec.op    = i30 ? ALU_SUB : ALU_ADD;
          end
          3'b110: begin
            dec.legal = 1'b1;
            dec.wb_en = 1'b1;
            dec.op    = ALU_OR;
          end
          3'b111: begin
            dec.legal = 1'b1;
            dec.wb_en = 1'b1;
            dec.op    = ALU_AND;
          end
          default: dec = '0;
        endcase
      end
      (opcode == OP_ADDI): begin
        dec.legal   = 1'b1;
        dec.alu_src = 1'b1;
        dec.op      = ALU_ADD;
        dec.wb_en   = 1'b1;
      end
      (opcode == OP_LW): begin
        dec.legal   = 1'b1;
        dec.alu_src = 1'b1;
        dec.op      = ALU_ADD;
        dec.is_lw   = 1'b1;
        dec.wb_en   = 1'b1;
      end
      (opcode == OP_SW): begin
        dec.legal   = 1'b1;
        dec.alu_src = 1'b1;
        dec.op      = ALU_ADD;
        dec.is_sw   = 1'b1;
      end
      (opcode == OP_BEQ): begin
        dec.legal = 1'b1;
        dec.op    = ALU_SUB;
        dec.is_br = 1'b1;
      end
      (opcode == OP_JAL): begin
        dec.legal   = 1'b1;
        dec.alu_src = 1'b1;
        dec.op      = ALU_ADD;
        dec.is_jal  = 1'b1;
        dec.wb_en   = 1'b1;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/[MEM]/WB,
// with entry-point load after reset and sticky halt causes.
module mc_control
  import ctrl_pkg::*;
#(
  parameter int COUNT_W     = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        ins,
  input  logic               zero,
  input  logic               run,
  input  logic               mem_ack,
  output logic               RegWrite,
  output logic               ALUSrc,
  output logic [2:0]         op,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Mem2Reg,
  output logic               mem_req,
  output logic               ir_load,
  output logic               pc_write,
  output logic [1:0]         pc_sel,
  output logic [2:0]         state,
  output logic [1:0]         halt_cause,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t       state_q;
  logic [6:0]   ir_op;
  logic [2:0]   ir_f3;
  logic         ir_i30;
  logic         zero_q;
  logic [WW-1:0] wait_cnt;
  dec_t         dec;
  logic         in_dw;
  logic         unused_ins;

  assign unused_ins = ^{ins[31], ins[29:15], ins[11:7]};

  mc_decode u_dec (
    .opcode (ir_op),
    .f3     (ir_f3),
    .i30    (ir_i30),
    .dec    (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RST;
      halt_cause  <= HC_NONE;
      instr_count <= '0;
      ir_op       <= '0;
      ir_f3       <= '0;
      ir_i30      <= 1'b0;
      zero_q      <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      unique case (state_q)
        S_RST:   state_q <= S_ENTRY;
        S_ENTRY: state_q <= S_FETCH;
        S_FETCH: begin
          if (run) begin
            ir_op   <= ins[6:0];
            ir_f3   <= ins[14:12];
            ir_i30  <= ins[30];
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (dec.legal) begin
            state_q <= S_EXEC;
          end else begin
            state_q    <= S_HALT;
            halt_cause <= HC_ILL;
          end
        end
        S_EXEC: begin
          zero_q   <= zero;
          wait_cnt <= '0;
          state_q  <= (dec.is_lw || dec.is_sw) ? S_MEM : S_WB;
        end
        S_MEM: begin
          // An ack on the last allowed cycle still wins over the timeout
          if (mem_ack) begin
            state_q <= S_WB;
          end else if (wait_cnt == WAIT_LAST) begin
            state_q    <= S_HALT;
            halt_cause <= HC_TO;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          instr_count <= instr_count + COUNT_W'(1);
          state_q     <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign state = state_q;
  assign in_dw = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                 (state_q == S_MEM) || (state_q == S_WB);

  always_comb begin
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    op       = 3'b000;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Mem2Reg  = 1'b0;
    mem_req  = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = PC_P4;
    if (in_dw) begin
      ALUSrc  = dec.alu_src;
      op      = dec.op;
      Mem2Reg = dec.is_lw;
    end
    unique case (state_q)
      S_ENTRY: begin
        pc_write = 1'b1;
        pc_sel   = PC_ENTRY;
      end
      S_FETCH: ir_load = run;
      S_MEM: begin
        mem_req  = 1'b1;
        MemRead  = dec.is_lw;
        MemWrite = dec.is_sw;
      end
      S_WB: begin
        pc_write = 1'b1;
        RegWrite = dec.wb_en;
        if (dec.is_br && zero_q) pc_sel = PC_BR;
        else if (dec.is_jal)     pc_sel = PC_JAL;
        else                     pc_sel = PC_P4;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expected outputs
// come from an instruction-level model and are checked by a monitor.
module tb_mc_control;

  localparam int TO = 4;

  typedef struct packed {
    logic [2:0]  st;
    logic        rw;
    logic        asrc;
    logic [2:0]  op;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        req;
    logic        irl;
    logic        pcw;
    logic [1:0]  psel;
    logic [1:0]  hc;
    logic [31:0] cnt;
  } vec_t;

  typedef struct packed {
    logic loose;
    vec_t v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = '0;
  logic        zero = 1'b0;
  logic        run = 1'b0;
  logic        mem_ack = 1'b0;
  logic        RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg;
  logic        mem_req, ir_load, pc_write;
  logic [2:0]  op, state;
  logic [1:0]  pc_sel, halt_cause;
  logic [31:0] instr_count;

  mc_control #(.COUNT_W(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .run(run),
    .mem_ack(mem_ack), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
    .op(op), .MemRead(MemRead), .MemWrite(MemWrite),
    .Mem2Reg(Mem2Reg), .mem_req(mem_req), .ir_load(ir_load),
    .pc_write(pc_write), .pc_sel(pc_sel), .state(state),
    .halt_cause(halt_cause), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   model_cnt = 0;
  logic [1:0] model_hc = 2'b00;

  function automatic vec_t sample();
    vec_t a;
    a.st = state; a.rw = RegWrite; a.asrc = ALUSrc; a.op = op;
    a.mr = MemRead; a.mw = MemWrite; a.m2r = Mem2Reg;
    a.req = mem_req; a.irl = ir_load; a.pcw = pc_write;
    a.psel = pc_sel; a.hc = halt_cause; a.cnt = instr_count;
    return a;
  endfunction

  task automatic check(input string nm, input vec_t a, input exp_t e);
    vec_t m;
    m = '1;
    if (e.loose) begin
      m.asrc = 1'b0; m.op = '0; m.m2r = 1'b0;
    end
    n_chk++;
    if (((a ^ e.v) & m) == '0) n_pass++;
    else $display("FAIL %s st=%0d actual=%h expected=%h mask=%h",
                  nm, e.v.st, a, e.v, m);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("cycle", sample(), e);
    end
  end

  function automatic vec_t base(input int s);
    vec_t v;
    v = '0;
    v.st = 3'(s);
    v.cnt = 32'(model_cnt);
    v.hc = model_hc;
    return v;
  endfunction

  // kinds: 0 add 1 sub 2 or 3 and 4 addi 5 lw 6 sw 7 beq 8 jal
  function automatic vec_t alu(input vec_t vi, input int k);
    vec_t v;
    v = vi;
    case (k)
      0: v.op = 3'b010;
      1: v.op = 3'b110;
      2: v.op = 3'b001;
      3: v.op = 3'b000;
      7: v.op = 3'b110;
      default: v.op = 3'b010;
    endcase
    v.asrc = (k >= 4 && k != 7);
    v.m2r = (k == 5);
    return v;
  endfunction

  function automatic logic [31:0] enc(input int k);
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] r;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    r = $urandom;
    case (k)
      0: return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      1: return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
      2: return {7'h00, rs2, rs1, 3'b110, rd, 7'h33};
      3: return {7'h00, rs2, rs1, 3'b111, rd, 7'h33};
      4: return {r[11:0], rs1, 3'b000, rd, 7'h13};
      5: return {r[11:0], rs1, 3'b010, rd, 7'h03};
      6: return {r[6:0], rs2, rs1, 3'b010, r[11:7], 7'h23};
      7: return {r[6:0], rs2, rs1, 3'b000, r[11:7], 7'h63};
      default: return {r[19:0], rd, 7'h6f};
    endcase
  endfunction

  task automatic push(input vec_t v, input logic loose);
    exp_t e;
    e.loose = loose;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic step(input vec_t v, input logic r, input logic [31:0] w,
                      input logic z, input logic ack);
    @(posedge clk);
    #1;
    run = r; ins = w; zero = z; mem_ack = ack;
    push(v, 1'b0);
  endtask

  // zsel<0 picks zero randomly; abort>0 stops after that many MEM cycles
  task automatic run_instr(input int k, input logic [31:0] w,
                           input int ack_d, input int gap,
                           input int zsel, input int abort);
    vec_t v;
    logic z;
    int nmem;
    for (int i = 0; i < gap; i++)
      step(base(2), 1'b0, $urandom, 1'($urandom), 1'($urandom));
    v = base(2); v.irl = 1'b1;
    step(v, 1'b1, w, 1'($urandom), 1'($urandom));
    step(alu(base(3), k), 1'($urandom), $urandom, 1'($urandom),
         1'($urandom));
    z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
    step(alu(base(4), k), 1'($urandom), $urandom, z, 1'($urandom));
    if (k == 5 || k == 6) begin
      nmem = (abort > 0) ? abort : ack_d;
      for (int i = 1; i <= nmem; i++) begin
        v = alu(base(5), k);
        v.req = 1'b1; v.mr = (k == 5); v.mw = (k == 6);
        step(v, 1'($urandom), $urandom, 1'($urandom),
             (abort == 0) && (i == ack_d));
      end
      if (abort > 0) return;
    end
    v = alu(base(6), k);
    v.pcw = 1'b1;
    v.rw = !(k == 6 || k == 7);
    v.psel = (k == 7 && z) ? 2'b01 : (k == 8) ? 2'b10 : 2'b00;
    step(v, 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    model_cnt++;
  endtask

  task automatic reset_pulse();
    exp_t e;
    vec_t v;
    @(posedge clk);
    #1;
    run = 1'b1;
    rst = 1'b1;
    #1;
    e = '0;
    check("async_reset", sample(), e);
    model_cnt = 0;
    model_hc = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(base(0), 1'b0);
    v = base(1); v.pcw = 1'b1; v.psel = 2'b11;
    step(v, 1'b0, $urandom, 1'b0, 1'($urandom));
  endtask

  task automatic halt_seq(input logic [31:0] w);
    vec_t v;
    v = base(2); v.irl = 1'b1;
    step(v, 1'b1, w, 1'b0, 1'b0);
    v = base(3);
    @(posedge clk);
    #1;
    push(v, 1'b1);
    model_hc = 2'b01;
    for (int i = 0; i < 5; i++)
      step(base(7), 1'b1, $urandom, 1'($urandom), 1'($urandom));
  endtask

  initial begin
    vec_t v;
    reset_pulse();
    run_instr(0, 32'h002081B3, 1, 0, -1, 0);
    run_instr(5, 32'h0000A183, 3, 0, -1, 0);
    run_instr(7, 32'h00208463, 1, 0, 1, 0);
    run_instr(7, 32'h00208463, 1, 1, 0, 0);
    for (int n = 0; n < 150; n++) begin
      int k;
      k = $urandom_range(0, 8);
      run_instr(k, enc(k), $urandom_range(1, TO),
                $urandom_range(0, 2), -1, 0);
    end
    // mid-MEM reset with instructions already retired
    run_instr(5, enc(5), 1, 0, -1, 2);
    reset_pulse();
    run_instr(4, enc(4), 1, 0, -1, 0);
    halt_seq(32'h0000007F);
    reset_pulse();
    halt_seq(32'h00209033);
    reset_pulse();
    run_instr(6, 32'h0020A023, 1, 0, -1, TO);
    model_hc = 2'b10;
    for (int i = 0; i < 4; i++)
      step(base(7), 1'b1, $urandom, 1'b0, 1'b1);
    reset_pulse();
    run_instr(8, enc(8), 1, 0, -1, 0);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d required=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
